// File: rtl/qmult_pipe.sv
// qmult_pipe: three-stage sign-magnitude Q-format multiplier
// with valid/ready flow control, rounding and saturation.
module qmult_pipe #(
    parameter int N = 32,
    parameter int Q = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [N-1:0] i_multiplicand,
    input  logic [N-1:0] i_multiplier,
    input  logic         i_round,
    input  logic         i_sat,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [N-1:0] o_result,
    output logic         o_ovr,
    output logic         o_ovr_sticky,
    input  logic         i_clr_ovr
);

    localparam int PW = 2*N-2;
    localparam int SW = 2*N-1;
    localparam logic [SW-1:0] HALF = SW'(1) << (Q-1);

    logic          s1_valid;
    logic          s1_sign;
    logic [PW-1:0] s1_mag;
    logic          s1_round;
    logic          s1_sat;

    logic          s2_valid;
    logic          s2_sign;
    logic [N-2:0]  s2_mag;
    logic          s2_ovr;
    logic          s2_sat;

    logic          stall;
    logic [PW-1:0] prod;
    logic [SW-1:0] sum;
    logic [SW-1:0] rsh;
    logic          ovr_c;
    logic [N-2:0]  mag_f;
    logic          sign_f;

    assign stall   = o_valid && !i_ready;
    assign o_ready = !stall;

    assign prod = {{(N-1){1'b0}}, i_multiplicand[N-2:0]}
                * {{(N-1){1'b0}}, i_multiplier[N-2:0]};

    // One spare top bit keeps the rounding carry visible to overflow.
    assign sum   = {1'b0, s1_mag} + (s1_round ? HALF : '0);
    assign rsh   = sum >> Q;
    assign ovr_c = |rsh[SW-1:N-1];

    assign mag_f  = (s2_ovr && s2_sat) ? '1 : s2_mag;
    assign sign_f = s2_sign && (mag_f != '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_mag   <= '0;
            s1_round <= 1'b0;
            s1_sat   <= 1'b0;
            s2_valid <= 1'b0;
            s2_sign  <= 1'b0;
            s2_mag   <= '0;
            s2_ovr   <= 1'b0;
            s2_sat   <= 1'b0;
            o_valid  <= 1'b0;
            o_result <= '0;
            o_ovr    <= 1'b0;
        end else if (!stall) begin
            s1_valid <= i_valid;
            s1_sign  <= i_multiplicand[N-1] ^ i_multiplier[N-1];
            s1_mag   <= prod;
            s1_round <= i_round;
            s1_sat   <= i_sat;
            s2_valid <= s1_valid;
            s2_sign  <= s1_sign;
            s2_mag   <= rsh[N-2:0];
            s2_ovr   <= ovr_c;
            s2_sat   <= s1_sat;
            o_valid  <= s2_valid;
            if (s2_valid) begin
                o_result <= {sign_f, mag_f};
                o_ovr    <= s2_ovr;
            end
        end
    end

    // A setting transfer takes priority over a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst)
            o_ovr_sticky <= 1'b0;
        else if (o_valid && i_ready && o_ovr)
            o_ovr_sticky <= 1'b1;
        else if (i_clr_ovr)
            o_ovr_sticky <= 1'b0;
    end

endmodule

// File: tb/tb_qmult_pipe.sv
// tb_qmult_pipe: directed and randomized checks of qmult_pipe
// against an arithmetic reference model.
module tb_qmult_pipe;

    localparam int N = 32;
    localparam int Q = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_multiplicand;
    logic [31:0] i_multiplier;
    logic        i_round;
    logic        i_sat;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_result;
    logic        o_ovr;
    logic        o_ovr_sticky;
    logic        i_clr_ovr;

    int checks   = 0;
    int failures = 0;

    // {ovr, result[31:0]}
    logic [32:0] exp_q[$];

    always #5 clk = ~clk;

    qmult_pipe #(.N(N), .Q(Q)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_multiplicand(i_multiplicand),
        .i_multiplier  (i_multiplier),
        .i_round       (i_round),
        .i_sat         (i_sat),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_result      (o_result),
        .o_ovr         (o_ovr),
        .o_ovr_sticky  (o_ovr_sticky),
        .i_clr_ovr     (i_clr_ovr)
    );

    function automatic logic [32:0] model(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic rnd,
                                          input logic sat);
        longint unsigned p;
        longint unsigned r;
        logic [30:0] m;
        logic s;
        logic ov;
        p = 64'(a[30:0]) * 64'(b[30:0]);
        if (rnd) p = p + (64'd1 << (Q-1));
        r = p / (64'd1 << Q);
        ov = (r >= 64'h8000_0000);
        if (ov && sat) m = 31'h7FFF_FFFF;
        else m = r[30:0];
        s = (m != 31'd0) && (a[31] ^ b[31]);
        return {ov, s, m};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] v;
        v = $urandom;
        if ($urandom_range(0, 3) != 0) v[30:0] = v[30:0] & 31'h0003_FFFF;
        if ($urandom_range(0, 9) == 0) v[30:0] = 31'd0;
        return v;
    endfunction

    task automatic send_one(input logic [31:0] a, input logic [31:0] b,
                            input logic rnd, input logic sat,
                            input logic clr,
                            output logic [31:0] res, output logic ov,
                            output logic st, output int lat);
        @(negedge clk);
        i_multiplicand = a;
        i_multiplier   = b;
        i_round        = rnd;
        i_sat          = sat;
        i_valid        = 1'b1;
        i_ready        = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        lat = 0;
        for (int n = 1; n <= 8; n++) begin
            if (o_valid) begin
                lat = n;
                break;
            end
            @(posedge clk);
            #1;
        end
        res = o_result;
        ov  = o_ovr;
        i_clr_ovr = clr;
        @(posedge clk);
        #1;
        i_clr_ovr = 1'b0;
        st = o_ovr_sticky;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (o_valid !== 1'b0 || o_result !== 32'd0 ||
            o_ovr !== 1'b0 || o_ovr_sticky !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got v=%b r=%h o=%b s=%b exp all 0",
                     o_valid, o_result, o_ovr, o_ovr_sticky);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (o_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got=%b exp=1", o_ready);
        end
    endtask

    task automatic test_identity();
        logic [31:0] res;
        logic ov, st;
        int lat;
        send_one(32'h0000_8000, 32'h0000_8000, 1'b0, 1'b0, 1'b0,
                 res, ov, st, lat);
        checks++;
        if (lat !== 3) begin
            failures++;
            $display("FAIL identity_latency got=%0d exp=3", lat);
        end
        checks++;
        if (res !== 32'h0000_8000 || ov !== 1'b0) begin
            failures++;
            $display("FAIL identity got=%h/%b exp=00008000/0", res, ov);
        end
    endtask

    task automatic test_sign_scale();
        logic [31:0] res;
        logic ov, st;
        int lat;
        send_one(32'h8000_C000, 32'h0001_0000, 1'b0, 1'b0, 1'b0,
                 res, ov, st, lat);
        checks++;
        if (res !== 32'h8001_8000 || ov !== 1'b0) begin
            failures++;
            $display("FAIL sign_scale got=%h/%b exp=80018000/0", res, ov);
        end
    endtask

    task automatic test_round_negzero();
        logic [31:0] res;
        logic ov, st;
        int lat;
        send_one(32'h8000_0001, 32'h0000_4000, 1'b0, 1'b0, 1'b0,
                 res, ov, st, lat);
        checks++;
        if (res !== 32'h0000_0000) begin
            failures++;
            $display("FAIL negzero_trunc got=%h exp=00000000", res);
        end
        send_one(32'h8000_0001, 32'h0000_4000, 1'b1, 1'b0, 1'b0,
                 res, ov, st, lat);
        checks++;
        if (res !== 32'h8000_0001) begin
            failures++;
            $display("FAIL round_half_up got=%h exp=80000001", res);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] res;
        logic ov, st;
        int lat;
        send_one(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0,
                 res, ov, st, lat);
        checks++;
        if (res !== 32'h7FFF_FFFF || ov !== 1'b1 || st !== 1'b1) begin
            failures++;
            $display("FAIL ovr_sat got=%h/%b/%b exp=7fffffff/1/1",
                     res, ov, st);
        end
        @(negedge clk);
        i_clr_ovr = 1'b1;
        @(negedge clk);
        i_clr_ovr = 1'b0;
        checks++;
        if (o_ovr_sticky !== 1'b0) begin
            failures++;
            $display("FAIL sticky_clear got=%b exp=0", o_ovr_sticky);
        end
        send_one(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1,
                 res, ov, st, lat);
        checks++;
        if (res !== 32'h7FFE_0000 || ov !== 1'b1 || st !== 1'b1) begin
            failures++;
            $display("FAIL ovr_wrap_setwins got=%h/%b/%b exp=7ffe0000/1/1",
                     res, ov, st);
        end
        send_one(32'h0000_8000, 32'h0000_8000, 1'b0, 1'b0, 1'b1,
                 res, ov, st, lat);
        checks++;
        if (ov !== 1'b0 || st !== 1'b0) begin
            failures++;
            $display("FAIL clr_on_plain_xfer got=%b/%b exp=0/0", ov, st);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] a [5];
        logic [31:0] b [5];
        logic [31:0] held;
        logic [32:0] e;
        logic have;
        int sent;
        int xf;
        sent = 0;
        xf = 0;
        have = 1'b0;
        held = '0;
        exp_q.delete();
        for (int i = 0; i < 5; i++) begin
            a[i] = $urandom & 32'h8003_FFFF;
            b[i] = $urandom & 32'h8003_FFFF;
        end
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            i_ready        = 1'b0;
            i_valid        = 1'b1;
            i_round        = 1'b0;
            i_sat          = 1'b0;
            i_multiplicand = a[sent];
            i_multiplier   = b[sent];
            #1;
            if (o_valid) begin
                if (!have) begin
                    held = o_result;
                    have = 1'b1;
                end else begin
                    checks++;
                    if (o_result !== held) begin
                        failures++;
                        $display("FAIL stall_stable got=%h exp=%h",
                                 o_result, held);
                    end
                end
            end
            if (i_valid && o_ready) begin
                exp_q.push_back(model(a[sent], b[sent], 1'b0, 1'b0));
                sent++;
            end
        end
        checks++;
        if (sent !== 3 || o_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_accept got=%0d/%b exp=3/0", sent, o_ready);
        end
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk);
            i_ready        = 1'b1;
            i_valid        = (sent < 5);
            i_multiplicand = a[sent < 5 ? sent : 0];
            i_multiplier   = b[sent < 5 ? sent : 0];
            #1;
            if (o_valid) begin
                xf++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL bp_extra got=%h exp=none", o_result);
                end else begin
                    e = exp_q.pop_front();
                    if ({o_ovr, o_result} !== e) begin
                        failures++;
                        $display("FAIL bp_order got=%h exp=%h",
                                 {o_ovr, o_result}, e);
                    end
                end
            end
            if (i_valid && o_ready) begin
                exp_q.push_back(model(i_multiplicand, i_multiplier,
                                      1'b0, 1'b0));
                sent++;
            end
        end
        i_valid = 1'b0;
        checks++;
        if (xf !== 5 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL bp_drain got=%0d left=%0d exp=5/0",
                     xf, exp_q.size());
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            i_ready        = 1'b1;
            i_valid        = 1'b1;
            i_round        = 1'b0;
            i_sat          = 1'b1;
            i_multiplicand = 32'h7FFF_FFFF;
            i_multiplier   = 32'h0001_0000 + 32'(i);
        end
        @(negedge clk);
        i_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        checks++;
        if (o_valid !== 1'b0 || o_result !== 32'd0 || o_ovr !== 1'b0 ||
            o_ovr_sticky !== 1'b0 || o_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid got=%b/%h/%b/%b/%b exp=0/0/0/0/1",
                     o_valid, o_result, o_ovr, o_ovr_sticky, o_ready);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (o_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL reset_discard got=%b exp=0", seen);
        end
    endtask

    task automatic test_random();
        logic [32:0] e;
        logic st_m;
        logic nxt;
        st_m = 1'b0;
        exp_q.delete();
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            i_valid        = (cyc < 590) && ($urandom_range(0, 3) != 0);
            i_ready        = ($urandom_range(0, 9) < 7);
            i_multiplicand = rand_op();
            i_multiplier   = rand_op();
            i_round        = $urandom_range(0, 1);
            i_sat          = $urandom_range(0, 1);
            i_clr_ovr      = ($urandom_range(0, 15) == 0);
            #1;
            checks++;
            if (o_ovr_sticky !== st_m) begin
                failures++;
                $display("FAIL rnd_sticky cyc=%0d got=%b exp=%b",
                         cyc, o_ovr_sticky, st_m);
            end
            nxt = i_clr_ovr ? 1'b0 : st_m;
            if (o_valid && i_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL rnd_extra got=%h exp=none", o_result);
                end else begin
                    e = exp_q.pop_front();
                    if (e[32]) nxt = 1'b1;
                    if ({o_ovr, o_result} !== e) begin
                        failures++;
                        $display("FAIL rnd_result cyc=%0d got=%h exp=%h",
                                 cyc, {o_ovr, o_result}, e);
                    end
                end
            end
            if (i_valid && o_ready)
                exp_q.push_back(model(i_multiplicand, i_multiplier,
                                      i_round, i_sat));
            st_m = nxt;
        end
        i_valid   = 1'b0;
        i_ready   = 1'b1;
        i_clr_ovr = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL rnd_lost got=%0d exp=0", exp_q.size());
        end
    endtask

    initial begin
        rst            = 1'b0;
        i_valid        = 1'b0;
        i_ready        = 1'b1;
        i_multiplicand = '0;
        i_multiplier   = '0;
        i_round        = 1'b0;
        i_sat          = 1'b0;
        i_clr_ovr      = 1'b0;
        test_reset();
        test_identity();
        test_sign_scale();
        test_round_negzero();
        test_overflow();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
